data_word_parallelizer: RTL and testbench

//  Width-doubling gearbox in the write-clock domain of the data-frame path. It packs

---
 rtl/data_word_parallelizer_pkg.sv | 7 +
 rtl/data_word_parallelizer_if.sv | 26 ++
 rtl/data_word_parallelizer.sv | 94 +++++++++
 tb/tb_data_word_parallelizer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/data_word_parallelizer_pkg.sv
// Shared constants for the data-frame width-doubling gearbox.
// The input word width is the only width parameter; the output is always twice as wide.
package data_word_parallelizer_pkg;

    localparam int DEFAULT_DIN_WIDTH = 128;

endpackage : data_word_parallelizer_pkg

// File: rtl/data_word_parallelizer_if.sv
// Ready/valid bus of the gearbox: narrow input side, wide output side, and the flush strobe.
import data_word_parallelizer_pkg::*;

interface data_word_parallelizer_if #(
    parameter int DIN_WIDTH = DEFAULT_DIN_WIDTH
);
    logic                     iVALID;
    logic                     oREADY;
    logic [DIN_WIDTH-1:0]     DIN;
    logic                     FLUSH;
    logic                     oVALID;
    logic                     iREADY;
    logic [2*DIN_WIDTH-1:0]   DOUT;

    // Upstream producer and downstream consumer combined (the environment side)
    modport master (
        output iVALID, DIN, FLUSH, iREADY,
        input  oREADY, oVALID, DOUT
    );

    // The gearbox itself
    modport slave (
        input  iVALID, DIN, FLUSH, iREADY,
        output oREADY, oVALID, DOUT
    );
endinterface : data_word_parallelizer_if

// File: rtl/data_word_parallelizer.sv
// Packs consecutive DIN_WIDTH words into one 2*DIN_WIDTH word, first word in the upper half.
// FLUSH emits a pending odd word padded with PAD_VALUE in the lower half.
module data_word_parallelizer
    import data_word_parallelizer_pkg::*;
#(
    parameter int                   DIN_WIDTH = DEFAULT_DIN_WIDTH,
    parameter logic [DIN_WIDTH-1:0] PAD_VALUE = {DIN_WIDTH{1'b0}}
) (
    input logic                     CLK,
    input logic                     RESET,
    data_word_parallelizer_if.slave bus
);

    logic [DIN_WIDTH-1:0]   hiWord_r;
    logic                   half_r;
    logic                   pending_r;
    logic [2*DIN_WIDTH-1:0] dout_r;
    logic                   oValid_r;

    logic                   outFree_s;
    logic                   flushFire_s;
    logic                   accept_s;
    logic                   halfNext_s;
    logic                   pendingNext_s;
    logic [DIN_WIDTH-1:0]   hiWordNext_s;
    logic [2*DIN_WIDTH-1:0] doutNext_s;
    logic                   oValidNext_s;

    // A ready flush owns the output slot, so input is refused that cycle and never merged into it
    assign outFree_s   = !oValid_r || bus.iREADY;
    assign flushFire_s = pending_r && half_r && outFree_s;
    assign bus.oREADY  = !RESET && !flushFire_s && (!half_r || outFree_s);
    assign accept_s    = bus.iVALID && bus.oREADY;

    assign bus.DOUT    = dout_r;
    assign bus.oVALID  = oValid_r;

    // Next-state for the half-pair, flush-pending flag and output register
    always_comb begin
        halfNext_s    = half_r;
        hiWordNext_s  = hiWord_r;
        doutNext_s    = dout_r;
        oValidNext_s  = oValid_r;
        pendingNext_s = pending_r;

        if (accept_s && !half_r) begin
            hiWordNext_s = bus.DIN;
            halfNext_s   = 1'b1;
        end else if (accept_s && half_r) begin
            halfNext_s   = 1'b0;
        end else if (flushFire_s) begin
            halfNext_s   = 1'b0;
        end else begin
            halfNext_s   = half_r;
        end

        if (accept_s && half_r) begin
            doutNext_s   = {hiWord_r, bus.DIN};
            oValidNext_s = 1'b1;
        end else if (flushFire_s) begin
            doutNext_s   = {hiWord_r, PAD_VALUE};
            oValidNext_s = 1'b1;
        end else if (oValid_r && bus.iREADY) begin
            oValidNext_s = 1'b0;
        end else begin
            oValidNext_s = oValid_r;
        end

        // A flush only survives if a lone word will be held after this edge
        if (flushFire_s) begin
            pendingNext_s = 1'b0;
        end else begin
            pendingNext_s = (pending_r || bus.FLUSH) && halfNext_s;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RESET) begin
            hiWord_r  <= {DIN_WIDTH{1'b0}};
            half_r    <= 1'b0;
            pending_r <= 1'b0;
            dout_r    <= {(2*DIN_WIDTH){1'b0}};
            oValid_r  <= 1'b0;
        end else begin
            hiWord_r  <= hiWordNext_s;
            half_r    <= halfNext_s;
            pending_r <= pendingNext_s;
            dout_r    <= doutNext_s;
            oValid_r  <= oValidNext_s;
        end
    end

endmodule : data_word_parallelizer

// File: tb/tb_data_word_parallelizer.sv
// Scoreboard bench for the data-frame gearbox: directed cases followed by random traffic.
module tb_data_word_parallelizer;
    localparam int W = 128;
    localparam logic [W-1:0] PAD = {W{1'b0}};

    logic CLK = 1'b0;
    logic RESET;
    int   checks = 0;
    int   failures = 0;
    int   validCycles = 0;
    logic [2*W-1:0] expQ[$];

    data_word_parallelizer_if #(.DIN_WIDTH(W)) bus ();

    data_word_parallelizer #(.DIN_WIDTH(W), .PAD_VALUE(PAD)) dut (
        .CLK  (CLK),
        .RESET(RESET),
        .bus  (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference model: words pair up in arrival order; a flush closes a lone word with padding
    logic [W-1:0] heldWord;
    bit           hasHeld = 0;
    always @(negedge CLK) begin
        bit completed;
        completed = 0;
        if (RESET) begin
            hasHeld = 0;
            expQ.delete();
        end else begin
            if (bus.iVALID && bus.oREADY) begin
                if (hasHeld) begin
                    expQ.push_back({heldWord, bus.DIN});
                    hasHeld   = 0;
                    completed = 1;
                end else begin
                    heldWord = bus.DIN;
                    hasHeld  = 1;
                end
            end
            if (bus.FLUSH && hasHeld && !completed) begin
                expQ.push_back({heldWord, PAD});
                hasHeld = 0;
            end
        end
    end

    // Monitor: compare every delivered word and check stability under backpressure
    logic [2*W-1:0] prevDout;
    bit             prevStall = 0;
    always @(negedge CLK) begin
        if (RESET) begin
            prevStall = 0;
        end else begin
            if (prevStall) begin
                check("stall_valid", {255'd0, bus.oVALID}, {255'd0, 1'b1});
                check("stall_dout", bus.DOUT, prevDout);
            end
            if (bus.oVALID) validCycles++;
            if (bus.oVALID && bus.iREADY) begin
                if (expQ.size() == 0) begin
                    check("unexpected_out", bus.DOUT, {(2*W){1'bx}});
                end else begin
                    check("dout", bus.DOUT, expQ.pop_front());
                end
            end
            prevStall = bus.oVALID && !bus.iREADY;
            prevDout  = bus.DOUT;
        end
    end

    task automatic send(input logic [W-1:0] d, input logic fl);
        bus.iVALID = 1'b1;
        bus.DIN    = d;
        bus.FLUSH  = fl;
        step();
        bus.iVALID = 1'b0;
        bus.FLUSH  = 1'b0;
    endtask

    initial begin
        int vc;
        int guard;
        RESET      = 1'b1;
        bus.iVALID = 1'b0;
        bus.DIN    = '0;
        bus.FLUSH  = 1'b0;
        bus.iREADY = 1'b1;
        repeat (3) step();
        check("rst_ovalid", {255'd0, bus.oVALID}, 256'd0);
        check("rst_dout", bus.DOUT, 256'd0);
        check("rst_oready", {255'd0, bus.oREADY}, 256'd0);
        RESET = 1'b0;
        #1;
        check("release_oready", {255'd0, bus.oREADY}, {255'd0, 1'b1});
        step();

        // Streaming: {1,2} and {3,4}, each valid for one cycle
        vc = validCycles;
        for (int i = 1; i <= 4; i++) begin
            bus.iVALID = 1'b1;
            bus.DIN    = W'(i);
            step();
        end
        bus.iVALID = 1'b0;
        repeat (3) step();
        check("stream_valid_cycles", 256'(validCycles - vc), 256'd2);

        // Backpressure: {5,6} held, 7 accepted, then not ready
        bus.iREADY = 1'b0;
        send(W'(5), 1'b0);
        send(W'(6), 1'b0);
        send(W'(7), 1'b0);
        check("bp_oready", {255'd0, bus.oREADY}, 256'd0);
        check("bp_dout", bus.DOUT, {128'd5, 128'd6});
        bus.iREADY = 1'b1;
        send(W'(8), 1'b0);
        check("bp_next", bus.DOUT, {128'd7, 128'd8});
        repeat (2) step();

        // Odd count with flush, then pairing resumes
        send(W'(9), 1'b0);
        bus.FLUSH = 1'b1;
        step();
        bus.FLUSH = 1'b0;
        repeat (3) step();
        send(W'(10), 1'b0);
        send(W'(11), 1'b0);
        repeat (2) step();

        // Flush with nothing held, and flush alongside a completing accept
        vc = validCycles;
        bus.FLUSH = 1'b1;
        step();
        bus.FLUSH = 1'b0;
        repeat (3) step();
        check("flush_idle", 256'(validCycles - vc), 256'd0);
        vc = validCycles;
        send(W'(12), 1'b0);
        send(W'(13), 1'b1);
        repeat (4) step();
        check("flush_on_pair", 256'(validCycles - vc), 256'd1);

        // Random traffic
        for (int c = 0; c < 10000; c++) begin
            bus.iVALID = ($urandom_range(0, 99) < 60);
            bus.iREADY = ($urandom_range(0, 99) < 65);
            bus.FLUSH  = ($urandom_range(0, 99) < 8);
            bus.DIN    = {$urandom, $urandom, $urandom, $urandom};
            step();
        end

        // Drain everything, closing any lone word
        bus.iVALID = 1'b0;
        bus.iREADY = 1'b1;
        bus.FLUSH  = 1'b1;
        step();
        bus.FLUSH  = 1'b0;
        guard = 0;
        while ((expQ.size() != 0 || bus.oVALID) && guard < 50) begin
            step();
            guard++;
        end
        check("drain_queue_empty", 256'(expQ.size()), 256'd0);
        check("drain_timeout", 256'(guard < 50), 256'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule : tb_data_word_parallelizer
